// File: rtl/spi_gyro_responder.sv
// -----------------------------------------------------------------------------
// spi_gyro_responder
//
// SPI responder (slave) that emulates a 3-axis gyro register map so the SPI
// master and gyro FSM can be exercised without the physical sensor.
// SPI mode 3 (CPOL=1, CPHA=1), MSB first. Everything runs on CLK; the SPI
// pins are treated as slow asynchronous inputs and synchronized.
//
// Frame format: one command byte (bit7 = read, bit6 = auto-increment,
// bits5:0 = register address) followed by any number of data bytes.
//
// Register map:
//   0x0F        WHO_AM_I (read-only, WHO_AM_I_VAL)
//   0x20..0x24  CTRL_REG1..5 (read/write, CTRL_REG1 resets to CTRL1_RST)
//   0x27        STATUS_REG (only with GYRO_STATUS_REG_EN, else reads 0x00)
//   0x28..0x2D  X lo/hi, Y lo/hi, Z lo/hi from the per-frame snapshot
//   others      read 0x00, writes ignored
//
// Optional feature macro: GYRO_STATUS_REG_EN (adds STATUS_REG at 0x27).
//
// Ports:
//   CLK          system clock, the only clock
//   RST_N        asynchronous active-low reset
//   SCLK         SPI clock from the master, idles high
//   SS           slave select, active-low
//   MOSI         master-out data
//   MISO         slave-out data (1 when not shifting read data)
//   MISO_OE      tristate enable, high while a frame is being served
//   X_IN/Y_IN/Z_IN  16-bit signed angular-rate samples
//   SAMPLE_VALID one-CLK pulse that latches X/Y/Z_IN into holding registers
//   CTRL1        current CTRL_REG1 contents
//   WR_STROBE    one-CLK pulse per completed register write
//   WR_ADDR      address of the last completed register write
//
// Debug: the FSM state is state_q (type state_t).
// -----------------------------------------------------------------------------
module spi_gyro_responder #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter logic [7:0] CTRL1_RST    = 8'h07,
    parameter int         SYNC_STAGES  = 2      // legal 2..3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SCLK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE,
    input  logic [15:0] X_IN,
    input  logic [15:0] Y_IN,
    input  logic [15:0] Z_IN,
    input  logic        SAMPLE_VALID,
    output logic [7:0]  CTRL1,
    output logic        WR_STROBE,
    output logic [5:0]  WR_ADDR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q,   ss_prev_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   SS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev_q &  sclk_s;
    assign sclk_fall =  sclk_prev_q & ~sclk_s;
    assign ss_rise   = ~ss_prev_q   &  ss_s;
    assign ss_fall   =  ss_prev_q   & ~ss_s;

    // The SS synchronizer and its edge register reset to 0 (not to the idle
    // level). A frame can therefore only start after SS has been seen high
    // since reset: if reset is released while SS is already low, no fall is
    // ever detected and the responder waits for a full SS high->low cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync_q <= '1;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample holding / snapshot registers
    // ------------------------------------------------------------------
    logic [15:0] hold_x_q, hold_x_d, hold_y_q, hold_y_d, hold_z_q, hold_z_d;
    logic [15:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_z_q, snap_z_d;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_in_q, shift_in_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic        rw_q, rw_d;
    logic        ms_q, ms_d;
    logic [5:0]  addr_q, addr_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q, miso_oe_d;
    logic [7:0]  ctrl1_q, ctrl1_d;
    logic [7:0]  ctrl2_q, ctrl2_d;
    logic [7:0]  ctrl3_q, ctrl3_d;
    logic [7:0]  ctrl4_q, ctrl4_d;
    logic [7:0]  ctrl5_q, ctrl5_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [5:0]  wr_addr_q, wr_addr_d;

    logic [7:0]  in_byte;       // shift_in with the bit arriving this CLK
    logic [5:0]  next_addr;     // address for the byte after the current one
    logic [5:0]  rd_addr;       // address whose contents get loaded next
    logic [7:0]  rd_data;
    logic        byte_done;     // 8th SCLK rise of a data byte, frame alive
    logic        rd_byte_done;

    assign in_byte      = {shift_in_q[6:0], mosi_s};
    assign next_addr    = ms_q ? (addr_q + 6'd1) : addr_q;
    assign byte_done    = (state_q == ST_DATA) && !ss_rise && sclk_rise &&
                          (bit_cnt_q == 3'd0);
    assign rd_byte_done = byte_done && rw_q;

    // At the end of the command byte the lookup uses the freshly received
    // address; at the end of a read data byte it uses the advanced address.
    always_comb begin
        rd_addr = next_addr;
        if (state_q == ST_CMD) begin
            rd_addr = in_byte[5:0];
        end
    end

`ifdef GYRO_STATUS_REG_EN
    // status_q[0]=XDA, [1]=YDA, [2]=ZDA
    logic [2:0] status_q, status_d;

    always_comb begin
        status_d = status_q;
        if (rd_byte_done) begin
            case (addr_q)
                6'h29:   status_d[0] = 1'b0;
                6'h2B:   status_d[1] = 1'b0;
                6'h2D:   status_d[2] = 1'b0;
                default: status_d = status_q;
            endcase
        end
        // A new sample in the same CLK as a clearing read wins.
        if (SAMPLE_VALID) begin
            status_d = 3'b111;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            status_q <= 3'b000;
        end else begin
            status_q <= status_d;
        end
    end
`endif

    // Register read mux
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            6'h0F: rd_data = WHO_AM_I_VAL;
            6'h20: rd_data = ctrl1_q;
            6'h21: rd_data = ctrl2_q;
            6'h22: rd_data = ctrl3_q;
            6'h23: rd_data = ctrl4_q;
            6'h24: rd_data = ctrl5_q;
`ifdef GYRO_STATUS_REG_EN
            6'h27: rd_data = {4'b0000, &status_q, status_q};
`endif
            6'h28: rd_data = snap_x_q[7:0];
            6'h29: rd_data = snap_x_q[15:8];
            6'h2A: rd_data = snap_y_q[7:0];
            6'h2B: rd_data = snap_y_q[15:8];
            6'h2C: rd_data = snap_z_q[7:0];
            6'h2D: rd_data = snap_z_q[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    // Next-state / datapath
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        rw_d        = rw_q;
        ms_d        = ms_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        ctrl1_d     = ctrl1_q;
        ctrl2_d     = ctrl2_q;
        ctrl3_d     = ctrl3_q;
        ctrl4_d     = ctrl4_q;
        ctrl5_d     = ctrl5_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        hold_x_d    = hold_x_q;
        hold_y_d    = hold_y_q;
        hold_z_d    = hold_z_q;
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        snap_z_d    = snap_z_q;

        if (SAMPLE_VALID) begin
            hold_x_d = X_IN;
            hold_y_d = Y_IN;
            hold_z_d = Z_IN;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b1;
                if (ss_fall) begin
                    // Freeze the sample for the whole frame; a sample arriving
                    // in this very CLK is taken directly.
                    snap_x_d  = SAMPLE_VALID ? X_IN : hold_x_q;
                    snap_y_d  = SAMPLE_VALID ? Y_IN : hold_y_q;
                    snap_z_d  = SAMPLE_VALID ? Z_IN : hold_z_q;
                    bit_cnt_d = 3'd7;
                    state_d   = ST_CMD;
                end
            end

            ST_CMD: begin
                miso_d = 1'b1;
                if (ss_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    shift_in_d = in_byte;
                    if (bit_cnt_q == 3'd0) begin
                        rw_d      = in_byte[7];
                        ms_d      = in_byte[6];
                        addr_d    = in_byte[5:0];
                        bit_cnt_d = 3'd7;
                        state_d   = ST_DATA;
                        if (in_byte[7]) begin
                            shift_out_d = rd_data;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end

            ST_DATA: begin
                if (ss_rise) begin
                    // Partial byte is dropped: no write, no address advance.
                    miso_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (sclk_fall && rw_q) begin
                        miso_d      = shift_out_q[7];
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_in_d = in_byte;
                        if (bit_cnt_q == 3'd0) begin
                            bit_cnt_d = 3'd7;
                            addr_d    = next_addr;
                            if (rw_q) begin
                                shift_out_d = rd_data;
                            end else begin
                                case (addr_q)
                                    6'h20: ctrl1_d = in_byte;
                                    6'h21: ctrl2_d = in_byte;
                                    6'h22: ctrl3_d = in_byte;
                                    6'h23: ctrl4_d = in_byte;
                                    6'h24: ctrl5_d = in_byte;
                                    default: ctrl1_d = ctrl1_q;
                                endcase
                                if ((addr_q >= 6'h20) && (addr_q <= 6'h24)) begin
                                    wr_strobe_d = 1'b1;
                                    wr_addr_d   = addr_q;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
            end

            default: begin
                miso_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        miso_oe_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd7;
            shift_in_q  <= 8'h00;
            shift_out_q <= 8'h00;
            rw_q        <= 1'b0;
            ms_q        <= 1'b0;
            addr_q      <= 6'h00;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            ctrl1_q     <= CTRL1_RST;
            ctrl2_q     <= 8'h00;
            ctrl3_q     <= 8'h00;
            ctrl4_q     <= 8'h00;
            ctrl5_q     <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 6'h00;
            hold_x_q    <= 16'h0000;
            hold_y_q    <= 16'h0000;
            hold_z_q    <= 16'h0000;
            snap_x_q    <= 16'h0000;
            snap_y_q    <= 16'h0000;
            snap_z_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            rw_q        <= rw_d;
            ms_q        <= ms_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            ctrl1_q     <= ctrl1_d;
            ctrl2_q     <= ctrl2_d;
            ctrl3_q     <= ctrl3_d;
            ctrl4_q     <= ctrl4_d;
            ctrl5_q     <= ctrl5_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            hold_x_q    <= hold_x_d;
            hold_y_q    <= hold_y_d;
            hold_z_q    <= hold_z_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_z_q    <= snap_z_d;
        end
    end

    assign MISO      = miso_q;
    assign MISO_OE   = miso_oe_q;
    assign CTRL1     = ctrl1_q;
    assign WR_STROBE = wr_strobe_q;
    assign WR_ADDR   = wr_addr_q;

endmodule

// File: tb/tb_spi_gyro_responder.sv
// -----------------------------------------------------------------------------
// Directed bench for spi_gyro_responder. Acts as an SPI mode-3 master with
// SCLK phases of HALF system clocks. Expected MISO bytes are queued before
// each frame and popped as bytes come back.
// -----------------------------------------------------------------------------
module tb_spi_gyro_responder;

    localparam int HALF = 8;

`ifdef GYRO_STATUS_REG_EN
    localparam logic [7:0] STATUS_FULL = 8'h0F;
`else
    localparam logic [7:0] STATUS_FULL = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [15:0] x_in, y_in, z_in;
    logic        sample_valid;
    logic [7:0]  ctrl1;
    logic        wr_strobe;
    logic [5:0]  wr_addr;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          w0;
    logic [7:0]  exp_q[$];
    logic [7:0]  tx_buf [0:15];
    logic [7:0]  rx;
    logic        b;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    spi_gyro_responder dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .SCLK         (sclk),
        .SS           (ss),
        .MOSI         (mosi),
        .MISO         (miso),
        .MISO_OE      (miso_oe),
        .X_IN         (x_in),
        .Y_IN         (y_in),
        .Z_IN         (z_in),
        .SAMPLE_VALID (sample_valid),
        .CTRL1        (ctrl1),
        .WR_STROBE    (wr_strobe),
        .WR_ADDR      (wr_addr)
    );

    // Counts CLK cycles with WR_STROBE high (one per completed write).
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) wr_cnt++;
    end

    // ---------------- checkers ----------------
    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        x_in = x;
        y_in = y;
        z_in = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Mode 3: drive on the falling edge, sample just before the rising edge.
    task automatic spi_bit(input logic mo, output logic mi);
        sclk = 1'b0;
        mosi = mo;
        repeat (HALF) @(negedge clk);
        mi = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        logic bit_in;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mo[i], bit_in);
            mi[i] = bit_in;
        end
    endtask

    // Sends tx_buf[0] (command) and tx_buf[1..n_data], then part_bits extra
    // bits of 1s, then raises SS. If sv_after matches a byte index, a sample
    // with X=sv_x is pulsed right after that byte.
    task automatic spi_frame(input string tag, input int n_data, input int part_bits,
                             input int sv_after, input logic [15:0] sv_x);
        logic [7:0] rxb;
        logic       bit_in;
        ss = 1'b0;
        repeat (HALF) @(negedge clk);
        check_byte({tag, "_oe_on"}, {7'b0, miso_oe}, 8'h01);
        for (int k = 0; k <= n_data; k++) begin
            spi_byte(tx_buf[k], rxb);
            if (exp_q.size() > 0) begin
                check_byte($sformatf("%s_byte%0d", tag, k), rxb, exp_q.pop_front());
            end
            if (k == sv_after) pulse_sample(sv_x, y_in, z_in);
        end
        for (int i = 0; i < part_bits; i++) spi_bit(1'b1, bit_in);
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (HALF) @(negedge clk);
        check_byte({tag, "_oe_off"}, {7'b0, miso_oe}, 8'h00);
        check_byte({tag, "_miso_idle"}, {7'b0, miso}, 8'h01);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        ss = 1'b1;
        sclk = 1'b1;
        mosi = 1'b0;
        x_in = 16'h0;
        y_in = 16'h0;
        z_in = 16'h0;
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);

        check_byte("rst_miso",    {7'b0, miso},      8'h01);
        check_byte("rst_miso_oe", {7'b0, miso_oe},   8'h00);
        check_byte("rst_ctrl1",   ctrl1,             8'h07);
        check_byte("rst_wr_strb", {7'b0, wr_strobe}, 8'h00);
        check_byte("rst_wr_addr", {2'b0, wr_addr},   8'h00);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        check_byte("post_rst_miso",    {7'b0, miso},    8'h01);
        check_byte("post_rst_miso_oe", {7'b0, miso_oe}, 8'h00);

        // WHO_AM_I read; command byte returns all ones
        tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'hD3);
        spi_frame("who_am_i", 1, 0, -1, 16'h0);

        // Write CTRL_REG1
        tx_buf[0] = 8'h20; tx_buf[1] = 8'h0F;
        w0 = wr_cnt;
        spi_frame("wr_ctrl1", 1, 0, -1, 16'h0);
        check_int("wr_ctrl1_strobes", wr_cnt - w0, 1);
        check_byte("wr_ctrl1_addr", {2'b0, wr_addr}, 8'h20);
        check_byte("wr_ctrl1_val", ctrl1, 8'h0F);

        // Readback without auto-increment: same register twice
        tx_buf[0] = 8'hA0; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
        spi_frame("rd_ctrl1", 2, 0, -1, 16'h0);

        // New sample, status register
        pulse_sample(16'h1234, 16'hABCD, 16'h8001);
        tx_buf[0] = 8'hA7; tx_buf[1] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(STATUS_FULL);
        spi_frame("status_set", 1, 0, -1, 16'h0);

        // Burst read with a new sample arriving mid-frame
        tx_buf[0] = 8'hE8;
        for (int i = 1; i <= 6; i++) tx_buf[i] = 8'h00;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        exp_q.push_back(8'hCD); exp_q.push_back(8'hAB);
        exp_q.push_back(8'h01); exp_q.push_back(8'h80);
        spi_frame("burst1", 6, 0, 2, 16'h5555);

        tx_buf[0] = 8'hA8; tx_buf[1] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        spi_frame("x_lo_new", 1, 0, -1, 16'h0);

        // Full burst clears XDA/YDA/ZDA
        tx_buf[0] = 8'hE8;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55); exp_q.push_back(8'h55);
        exp_q.push_back(8'hCD); exp_q.push_back(8'hAB);
        exp_q.push_back(8'h01); exp_q.push_back(8'h80);
        spi_frame("burst2", 6, 0, -1, 16'h0);
        tx_buf[0] = 8'hA7; tx_buf[1] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        spi_frame("status_clr", 1, 0, -1, 16'h0);

        // Address wrap 0x3F -> 0x00
        tx_buf[0] = 8'hFF; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        spi_frame("wrap", 2, 0, -1, 16'h0);

        // Write to read-only WHO_AM_I is ignored
        tx_buf[0] = 8'h0F; tx_buf[1] = 8'h00;
        w0 = wr_cnt;
        spi_frame("wr_ro", 1, 0, -1, 16'h0);
        check_int("wr_ro_strobes", wr_cnt - w0, 0);
        check_byte("wr_ro_addr", {2'b0, wr_addr}, 8'h20);
        tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'hD3);
        spi_frame("who_after_wr", 1, 0, -1, 16'h0);

        // Write to snapshot register is ignored
        tx_buf[0] = 8'h28; tx_buf[1] = 8'h99;
        w0 = wr_cnt;
        spi_frame("wr_snap", 1, 0, -1, 16'h0);
        check_int("wr_snap_strobes", wr_cnt - w0, 0);

        // Partial data byte (5 bits) then SS high: no write
        tx_buf[0] = 8'h21;
        w0 = wr_cnt;
        spi_frame("partial", 0, 5, -1, 16'h0);
        check_int("partial_strobes", wr_cnt - w0, 0);
        tx_buf[0] = 8'hA1; tx_buf[1] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        spi_frame("rd_ctrl2", 1, 0, -1, 16'h0);

        // Auto-increment write burst, then burst read CTRL_REG1..5
        tx_buf[0] = 8'h61; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
        w0 = wr_cnt;
        spi_frame("wr_burst", 2, 0, -1, 16'h0);
        check_int("wr_burst_strobes", wr_cnt - w0, 2);
        check_byte("wr_burst_addr", {2'b0, wr_addr}, 8'h22);
        tx_buf[0] = 8'hE0;
        for (int i = 1; i <= 5; i++) tx_buf[i] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h0F); exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        spi_frame("rd_ctrl_all", 5, 0, -1, 16'h0);

        // Reset in the middle of a read frame, SS kept low afterwards
        ss = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'hA8, rx);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_byte("midrst_miso",    {7'b0, miso},    8'h01);
        check_byte("midrst_miso_oe", {7'b0, miso_oe}, 8'h00);
        check_byte("midrst_ctrl1",   ctrl1,           8'h07);
        check_byte("midrst_wr_addr", {2'b0, wr_addr}, 8'h00);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        w0 = wr_cnt;
        spi_byte(8'h20, rx);
        check_byte("ignored_cmd_miso", rx, 8'hFF);
        spi_byte(8'h55, rx);
        check_byte("ignored_data_miso", rx, 8'hFF);
        check_int("ignored_strobes", wr_cnt - w0, 0);
        check_byte("ignored_ctrl1", ctrl1, 8'h07);
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        tx_buf[0] = 8'hA0; tx_buf[1] = 8'h00;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h07);
        spi_frame("rd_after_rst", 1, 0, -1, 16'h0);

        check_int("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_gyro_responder.md
Name: spi_gyro_responder

Overview:
- SPI slave (responder) that emulates the 3-axis gyro register map, so the existing SPI master and gyro FSM can be exercised and demoed without the physical Pmod.
- Sits on the same four-wire JA bus (SS, MOSI, MISO, SCLK) on a second board or in the system bench.
- Serves WHO_AM_I, CTRL_REG1..5 and OUT_X/Y/Z from sample inputs.
- SPI mode 3 (CPOL=1, CPHA=1), MSB first.

Parameters:
- WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F.
- CTRL1_RST, 8'h07, reset value of CTRL_REG1 (0x20).
- SYNC_STAGES, 2, flip-flop stages on SCLK/SS/MOSI into the CLK domain (legal 2..3).

Ports:
- CLK  in  1  system clock, the only clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- SCLK  in  1  SPI clock from master; idles high.
- SS  in  1  slave select, active-low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- MISO_OE  out  1  high while SS is low (synchronized); tristate enable.
- X_IN, Y_IN, Z_IN  in  16 each  signed angular-rate samples.
- SAMPLE_VALID  in  1  one-CLK pulse; latches X/Y/Z_IN into holding registers.
- CTRL1  out  8  current CTRL_REG1 contents.
- WR_STROBE  out  1  one-CLK pulse per completed register write.
- WR_ADDR  out  6  address of the last completed write.

Behaviour:
- Reset values: MISO=1, MISO_OE=0, CTRL1=CTRL1_RST, CTRL_REG2..5=0, WR_STROBE=0, WR_ADDR=0, holding and snapshot registers=0, state=IDLE.
- Synchronization: SCLK, SS and MOSI pass through SYNC_STAGES flops. Rise/fall detect on the synchronized SCLK and SS.
  - Timing requirement: SCLK high and low phases each ≥4 CLK.
  - MISO changes ≤SYNC_STAGES+1 CLK after a real SCLK fall.
- States:
  - IDLE: wait for SS fall. On SS fall, copy the holding registers into the snapshot, so multi-byte reads are coherent. Go to CMD, bit_cnt=7.
  - CMD: sample MOSI on each SCLK rise.
    - After 8 bits: bit7=RW (1=read), bit6=MS (auto-increment), bits5:0=addr pointer. Go to DATA.
    - For a read, load shift_out with reg[addr]; its MSB is presented on the next SCLK fall.
  - DATA, read: shift out on SCLK fall, MSB first. After each byte, if MS=1 then addr+1 (wraps 0x3F->0x00), else addr unchanged. Reload shift_out.
  - DATA, write: shift in on SCLK rise. After 8 bits, write reg[addr] if it is writable, pulse WR_STROBE for 1 CLK and update WR_ADDR. Advance addr per MS.
  - Any state: SS rise -> IDLE. Partial byte discarded, no write, MISO=1.
- During CMD byte MISO=1.
- Register map:
  - 0x0F: WHO_AM_I_VAL, read-only.
  - 0x20-0x24: CTRL_REG1-5, read/write.
  - 0x28/0x29: X lo/hi; 0x2A/0x2B: Y lo/hi; 0x2C/0x2D: Z lo/hi. All from the snapshot, read-only.
  - All other addresses read 0x00.
  - Writes to read-only or unmapped addresses are ignored: no WR_STROBE.
- SAMPLE_VALID during a transaction updates only the holding registers, never the snapshot.
- SAMPLE_VALID and SS fall in the same CLK: the snapshot takes the new X/Y/Z_IN values.
- Reset mid-transaction:
  - Immediate return to reset values.
  - After reset release, if SS is already low, stay in IDLE until SS goes high, then low again. No mid-frame resync.

Optional Feature:
- Macro GYRO_STATUS_REG_EN.
- Defined: address 0x27 = STATUS_REG.
  - Bits 2:0 = ZDA/YDA/XDA, all set on SAMPLE_VALID.
  - XDA clears when byte 0x29 completes a read, YDA on 0x2B, ZDA on 0x2D.
  - Bit 3 = ZYXDA = AND of bits 2:0. Bits 7:4 = 0.
  - Set and clear in the same CLK: set wins.
- Undefined: 0x27 reads 0x00; no status flops.

Test Plan:
- Reset, SS high -> MISO=1, MISO_OE=0, CTRL1=0x07. Read 0x0F (cmd 0x8F) -> MISO byte 0xD3, MISO_OE=1 during frame.
- Write cmd 0x20, data 0x0F -> WR_STROBE one pulse, WR_ADDR=0x20, CTRL1=0x0F. Readback cmd 0xA0 -> 0x0F.
- SAMPLE_VALID with X=0x1234, Y=0xABCD, Z=0x8001. Burst read cmd 0xE8, 6 bytes -> 34 12 CD AB 01 80. SAMPLE_VALID with X=0x5555 mid-burst -> burst unchanged; next frame returns 0x55 at 0x28.
- Burst read cmd 0xFF, 2 bytes -> address 0x3F then wraps to 0x00, both 0x00. Write cmd 0x0F data 0x00 -> no WR_STROBE, WHO_AM_I still 0xD3.
- Write cmd 0x21, SS raised after 5 data bits -> CTRL_REG2 stays 0x00, no WR_STROBE. Assert RST_N low mid-read with SS low, then release -> responder ignores until an SS high->low cycle; next read of 0x20 returns 0x07.
- GYRO_STATUS_REG_EN defined: SAMPLE_VALID -> read 0x27 = 0x0F. Burst 0x28-0x2D, then read 0x27 = 0x00. Undefined: 0x27 reads 0x00.
